// File: rtl/uart_cmd_parser.sv
// Frame parser from uart_rx bytes to pulse-generator settings.
// Define CMD_CSUM_EN to append and verify an XOR checksum byte.
module uart_cmd_parser #(
    parameter int          CLK_FREQ       = 50_000_000,
    parameter int          TIMEOUT_CYCLES = CLK_FREQ / 500,
    parameter logic [7:0]  HEADER         = 8'h07,
    parameter logic [15:0] RST_WIDTH      = 16'd5
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  po_data,
    input  logic        po_flag,
    output logic [15:0] pulse_width1,
    output logic [15:0] pulse_width2,
    output logic [15:0] pulse_gap,
    output logic [1:0]  ch_en,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        busy
);

`ifdef CMD_CSUM_EN
    localparam int FRAME_LEN = 10;
`else
    localparam int FRAME_LEN = 9;
`endif
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic [1:0]  pen_q, pen_d;
    logic [15:0] pw1_q, pw1_d;
    logic [15:0] pw2_q, pw2_d;
    logic [15:0] pgap_q, pgap_d;
    logic [15:0] w1_q, w1_d;
    logic [15:0] w2_q, w2_d;
    logic [15:0] gap_q, gap_d;
    logic [1:0]  en_q, en_d;
    logic        cv_q, cv_d;
    logic        fe_q, fe_d;
    logic        csum_ok;
    logic        last;
`ifdef CMD_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    // Pending fields with the current byte merged into its slot.
    always_comb begin
        pen_d  = pen_q;
        pw1_d  = pw1_q;
        pw2_d  = pw2_q;
        pgap_d = pgap_q;
        case (cnt_q)
            4'd1:    pen_d[0]      = po_data[0];
            4'd2:    pen_d[1]      = po_data[0];
            4'd3:    pw1_d[15:8]   = po_data;
            4'd4:    pw1_d[7:0]    = po_data;
            4'd5:    pw2_d[15:8]   = po_data;
            4'd6:    pw2_d[7:0]    = po_data;
            4'd7:    pgap_d[15:8]  = po_data;
            4'd8:    pgap_d[7:0]   = po_data;
            default: ;
        endcase
    end

    assign last = (cnt_q == 4'(FRAME_LEN - 1));
`ifdef CMD_CSUM_EN
    assign csum_ok = (csum_q == po_data);
`else
    assign csum_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        gap_d   = gap_q;
        en_d    = en_q;
        cv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef CMD_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                to_d  = '0;
                if (po_flag && po_data == HEADER) begin
                    state_d = RECV;
                    cnt_d   = 4'd1;
`ifdef CMD_CSUM_EN
                    csum_d  = po_data;
`endif
                end
            end
            RECV: begin
                if (po_flag) begin
                    to_d = '0;
                    if (last) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                        if (csum_ok) begin
                            w1_d  = pw1_d;
                            w2_d  = pw2_d;
                            gap_d = pgap_d;
                            en_d  = pen_d;
                            cv_d  = 1'b1;
                        end else begin
                            fe_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
`ifdef CMD_CSUM_EN
                        csum_d = csum_q ^ po_data;
`endif
                    end
                end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    to_d    = '0;
                    fe_d    = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            to_q    <= '0;
            pen_q   <= 2'b00;
            pw1_q   <= 16'd0;
            pw2_q   <= 16'd0;
            pgap_q  <= 16'd0;
            w1_q    <= RST_WIDTH;
            w2_q    <= RST_WIDTH;
            gap_q   <= RST_WIDTH;
            en_q    <= 2'b11;
            cv_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef CMD_CSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            if (state_q == RECV && po_flag) begin
                pen_q  <= pen_d;
                pw1_q  <= pw1_d;
                pw2_q  <= pw2_d;
                pgap_q <= pgap_d;
            end
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            cv_q    <= cv_d;
            fe_q    <= fe_d;
`ifdef CMD_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign pulse_width1 = w1_q;
    assign pulse_width2 = w2_q;
    assign pulse_gap    = gap_q;
    assign ch_en        = en_q;
    assign cmd_valid    = cv_q;
    assign frame_err    = fe_q;
    assign busy         = (state_q == RECV);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: vector table plus scoreboard
// of expected commits, with hand-written timeout/reset/back-to-back cases.
module tb_uart_cmd_parser;

    localparam int T = 40;
`ifdef CMD_CSUM_EN
    localparam int FL = 10;
`else
    localparam int FL = 9;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  po_data = 8'h00;
    logic        po_flag = 1'b0;
    logic [15:0] pulse_width1, pulse_width2, pulse_gap;
    logic [1:0]  ch_en;
    logic        cmd_valid, frame_err, busy;

    uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .po_data      (po_data),
        .po_flag      (po_flag),
        .pulse_width1 (pulse_width1),
        .pulse_width2 (pulse_width2),
        .pulse_gap    (pulse_gap),
        .ch_en        (ch_en),
        .cmd_valid    (cmd_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [71:0] by;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] gap;
        logic [1:0]  en;
    } vec_t;

    typedef struct packed {
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] gap;
        logic [1:0]  en;
    } exp_t;

    vec_t tbl [4];
    exp_t sb [$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;
    int   fe_cnt = 0;
    int   cv_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (frame_err) fe_cnt++;
            if (cmd_valid || frame_err)
                chk("strobe_excl", {63'd0, cmd_valid & frame_err}, 64'd0);
            if (cmd_valid) begin
                cv_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_cmd_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cmd_w1", 64'(pulse_width1), 64'(e.w1));
                    chk("cmd_w2", 64'(pulse_width2), 64'(e.w2));
                    chk("cmd_gap", 64'(pulse_gap), 64'(e.gap));
                    chk("cmd_en", 64'(ch_en), 64'(e.en));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        po_data = b;
        po_flag = 1'b1;
        @(negedge sys_clk);
        po_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk_outs(input string name, input exp_t e);
        chk(name, {14'd0, pulse_width1, pulse_width2, pulse_gap, ch_en},
            {14'd0, e.w1, e.w2, e.gap, e.en});
    endtask

    task automatic send_frame(input vec_t v, input int gap, input int gap0,
                              input logic bad);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        for (int i = 0; i < FL; i++) begin
            if (i < 9) begin
                b = v.by[71 - 8*i -: 8];
                cs = cs ^ b;
            end else begin
                b = cs ^ {7'd0, bad};
            end
            if (i == FL - 1) begin
                chk("busy_mid", {63'd0, busy}, 64'd1);
                if (!bad) begin
                    sb.push_back({v.w1, v.w2, v.gap, v.en});
                    last_exp = {v.w1, v.w2, v.gap, v.en};
                end
                send_byte(b);
                chk("cv_latency", {63'd0, cmd_valid}, {63'd0, !bad});
                chk("busy_end", {63'd0, busy}, 64'd0);
            end else begin
                send_byte(b);
                idle(i == 0 ? gap0 : gap);
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fe0;
        int cv0;
        exp_t rst_exp;
        rst_exp = {16'd5, 16'd5, 16'd5, 2'b11};
        tbl[0] = {72'h07_01_00_00_64_00_C8_01_F4,
                  16'd100, 16'd200, 16'd500, 2'b01};
        tbl[1] = {72'h07_00_01_12_34_AB_CD_00_00,
                  16'h1234, 16'hABCD, 16'h0000, 2'b10};
        tbl[2] = {72'h07_FF_FE_FF_FF_00_00_07_07,
                  16'hFFFF, 16'h0000, 16'h0707, 2'b01};
        tbl[3] = {72'h07_00_00_00_01_00_02_00_03,
                  16'd1, 16'd2, 16'd3, 2'b00};

        idle(3);
        sys_rst_n = 1'b1;
        chk_outs("reset_outs", rst_exp);
        chk("reset_strobes", {61'd0, cmd_valid, frame_err, busy}, 64'd0);
        last_exp = rst_exp;

        fe0 = fe_cnt;
        send_byte(8'h55);
        idle(2);
        send_byte(8'hAA);
        idle(2);
        chk("noise_busy", {63'd0, busy}, 64'd0);
        chk("noise_no_err", 64'(fe_cnt - fe0), 64'd0);
        send_frame(tbl[0], 1, 1, 1'b0);
        idle(1);

        for (int k = 0; k < 4; k++) begin
            send_frame(tbl[k], 2, 2, 1'b0);
            idle(1);
            chk("cv_one_cycle", {63'd0, cmd_valid}, 64'd0);
            chk_outs("hold_outs", last_exp);
        end

        fe0 = fe_cnt;
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h0A);
        idle(T - 1);
        chk("to_early", {62'd0, frame_err, busy}, 64'd1);
        idle(1);
        chk("to_fire", {62'd0, frame_err, busy}, 64'd2);
        chk_outs("to_outs", last_exp);
        idle(1);
        chk("to_one_cycle", {63'd0, frame_err}, 64'd0);
        chk("to_count", 64'(fe_cnt - fe0), 64'd1);
        send_frame(tbl[0], 1, 1, 1'b0);
        idle(2);

        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        sys_rst_n = 1'b0;
        idle(1);
        sys_rst_n = 1'b1;
        chk_outs("midrst_outs", rst_exp);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        last_exp = rst_exp;
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'h9A);
        send_byte(8'hBC);
        idle(3);
        chk("midrst_no_cv", 64'(cv_cnt - cv0), 64'd0);
        chk("midrst_no_fe", 64'(fe_cnt - fe0), 64'd0);
        chk_outs("midrst_hold", rst_exp);

        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(tbl[1], 0, 0, 1'b0);
        send_frame(tbl[2], 0, 0, 1'b0);
        idle(1);
        chk("b2b_count", 64'(cv_cnt - cv0), 64'd2);
        chk_outs("b2b_final", {tbl[2].w1, tbl[2].w2, tbl[2].gap, tbl[2].en});
        send_frame(tbl[3], 1, T - 1, 1'b0);
        idle(2);
        chk("thresh_no_fe", 64'(fe_cnt - fe0), 64'd0);
        chk_outs("thresh_outs", {tbl[3].w1, tbl[3].w2, tbl[3].gap, tbl[3].en});

`ifdef CMD_CSUM_EN
        fe0 = fe_cnt;
        cv0 = cv_cnt;
        send_frame(tbl[1], 1, 1, 1'b1);
        idle(1);
        chk("csum_bad_fe", 64'(fe_cnt - fe0), 64'd1);
        chk("csum_bad_no_cv", 64'(cv_cnt - cv0), 64'd0);
        chk_outs("csum_bad_outs", last_exp);
        send_frame(tbl[0], 1, 1, 1'b0);
        idle(2);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
